sram16_ctrl: RTL

- Avalon-MM slave controller, 32-bit data, that drives an external 16-bit asynchronous SRAM.
- Sits directly downstream of the 16-to-32 bus bridge and consumes its wide master port (address, byteenable, writedata, read, write, waitrequest).
- Each 32-bit access becomes up to two 16-bit SRAM cycles: low half first, then high half.
- Access timing is set by a wait-state parameter.

---
 rtl/sram16_pkg.sv | 20 ++
 rtl/sram16_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram16_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
//   state_e  : controller FSM states
//   HALF_LO  : low 16-bit half of a 32-bit word (SRAM address LSB = 0)
//   HALF_HI  : high 16-bit half of a 32-bit word (SRAM address LSB = 1)
//   WCNT_W   : width of the per-half wait-state counter
package sram16_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/sram16_ctrl.sv
// Avalon-MM 32-bit slave driving an external 16-bit asynchronous SRAM.
// Each 32-bit transfer becomes up to two 16-bit SRAM cycles (low half first),
// each holding the strobes for WAIT clocks; writes add one HOLD clock per half.
//
// Ports:
//   clock, sreset          : clock, synchronous active-high reset
//   s_address/s_byteenable : word address, byte enables ([1:0] low, [3:2] high)
//   s_writedata/s_readdata : 32-bit write data / read data (valid in ack cycle)
//   s_read/s_write         : requests held until accepted (write wins if both)
//   s_waitrequest          : combinational stall, low only in DONE
//   sram_addr              : halfword address {word address, half}
//   sram_dq_out/_oe/_in    : pad data out, pad output enable, pad data in
//   sram_ce_n/oe_n/we_n    : chip enable, output enable, write enable (active low)
//   sram_ub_n/lb_n         : upper/lower byte enables (active low)
module sram16_ctrl
  import sram16_pkg::*;
#(
  parameter int unsigned WIDTHA = 17,
  parameter int unsigned WAIT   = 2
) (
  input  logic              clock,
  input  logic              sreset,
  input  logic [WIDTHA-1:0] s_address,
  input  logic [3:0]        s_byteenable,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  input  logic              s_read,
  input  logic              s_write,
  output logic              s_waitrequest,
  output logic [WIDTHA:0]   sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT - 1);

  // Control state
  state_e              state_q, state_d;
  logic                half_q, half_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                is_wr_q, is_wr_d;

  // Latched request
  logic [WIDTHA-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;

  // Read capture and response
  logic [15:0]         rd_lo_q, rd_lo_d;
  logic [15:0]         rd_hi_q, rd_hi_d;
  logic [31:0]         rdata_q, rdata_d;

  // Registered pad drivers
  logic [WIDTHA:0]     sram_addr_q, sram_addr_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;

  logic [1:0]          be_pair_c;

  // Stall every request except in the single DONE clock.
  assign s_waitrequest = (s_read | s_write) & (state_q != DONE);

  assign s_readdata  = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = ub_n_q;
  assign sram_lb_n   = lb_n_q;

  // Next-state, request latch and read capture.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    wcnt_d  = wcnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_lo_d = rd_lo_q;
    rd_hi_d = rd_hi_q;

    unique case (state_q)
      IDLE: begin
        if (s_read || s_write) begin
          addr_d  = s_address;
          be_d    = s_byteenable;
          wdata_d = s_writedata;
          is_wr_d = s_write;
          wcnt_d  = '0;
          if (s_write) begin
            // Start on the first half that has any byte enabled.
            if (s_byteenable[1:0] != 2'b00) begin
              state_d = ACCESS;
              half_d  = HALF_LO;
            end else if (s_byteenable[3:2] != 2'b00) begin
              state_d = ACCESS;
              half_d  = HALF_HI;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = ACCESS;
            half_d  = HALF_LO;
          end
        end
      end

      ACCESS: begin
        if (wcnt_q == WCNT_LAST) begin
          wcnt_d = '0;
          if (is_wr_q) begin
            state_d = HOLD;
          end else begin
            // Data has been stable for the whole strobe; sample it now.
            if (half_q == HALF_LO) begin
              rd_lo_d = sram_dq_in;
              half_d  = HALF_HI;
            end else begin
              rd_hi_d = sram_dq_in;
              state_d = DONE;
            end
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      HOLD: begin
        if ((half_q == HALF_LO) && (be_q[3:2] != 2'b00)) begin
          state_d = ACCESS;
          half_d  = HALF_HI;
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pad values for the upcoming state, so the pads change only on clock edges.
  always_comb begin
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    rdata_d     = rdata_q;
    be_pair_c   = (half_d == HALF_HI) ? be_d[3:2] : be_d[1:0];

    case (state_d)
      ACCESS: begin
        ce_n_d      = 1'b0;
        sram_addr_d = {addr_d, half_d};
        if (is_wr_d) begin
          we_n_d   = 1'b0;
          dq_oe_d  = 1'b1;
          dq_out_d = (half_d == HALF_HI) ? wdata_d[31:16] : wdata_d[15:0];
          ub_n_d   = ~be_pair_c[1];
          lb_n_d   = ~be_pair_c[0];
        end else begin
          // Reads always fetch the full halfword.
          oe_n_d = 1'b0;
          ub_n_d = 1'b0;
          lb_n_d = 1'b0;
        end
      end

      HOLD: begin
        // Write strobe released; address, data and byte lanes held.
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        ub_n_d  = ub_n_q;
        lb_n_d  = lb_n_q;
      end

      DONE: begin
        rdata_d = {rd_hi_d, rd_lo_d};
      end

      default: begin
      end
    endcase
  end

  // State and pad registers.
  always_ff @(posedge clock) begin
    if (sreset) begin
      state_q     <= IDLE;
      half_q      <= HALF_LO;
      wcnt_q      <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rd_lo_q     <= '0;
      rd_hi_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      wcnt_q      <= wcnt_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rd_lo_q     <= rd_lo_d;
      rd_hi_q     <= rd_hi_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
    end
  end

endmodule
